// File: rtl/fc_pkg.sv
// Shared types and defaults for the fully-connected layer feeder.
package fc_pkg;

  localparam int unsigned WORD_SIZE_DEF = 16;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2
  } fc_state_e;

endpackage

// File: rtl/fc_layer_feeder.sv
// Collects INPUT_HEIGHT upstream words into a vector, pulses start to the
// downstream node, then waits for its completion before refilling.
module fc_layer_feeder
  import fc_pkg::*;
#(
  parameter int unsigned INPUT_HEIGHT = 4,
  parameter int unsigned WORD_SIZE    = WORD_SIZE_DEF,
  parameter int unsigned COUNT_WIDTH  = 8
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic                                    valid_i,
  input  logic [WORD_SIZE-1:0]                    data_i,
  output logic                                    ready_o,
  output logic [INPUT_HEIGHT-1:0][WORD_SIZE-1:0]  data_o,
  output logic                                    start_o,
  input  logic                                    done_i,
  output logic                                    busy_o,
  output logic [COUNT_WIDTH-1:0]                  vec_count_o
);

  localparam int unsigned IDX_W = $clog2(INPUT_HEIGHT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INPUT_HEIGHT - 1);

  fc_state_e r_state;
  fc_state_e w_next;

  logic [IDX_W-1:0]                    r_idx;
  logic [INPUT_HEIGHT-1:0][WORD_SIZE-1:0] r_data;
  logic [COUNT_WIDTH-1:0]              r_count;
  // Holds ready low until the first clock edge after reset release.
  logic                                r_live;
  logic                                w_hs;
  logic                                w_last;

  assign w_hs   = (r_state == FILL) && r_live && valid_i;
  assign w_last = (r_idx == IDX_LAST);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    ready_o = 1'b0;
    start_o = 1'b0;
    busy_o  = 1'b1;
    case (r_state)
      FILL: begin
        ready_o = r_live;
        busy_o  = 1'b0;
        if (w_hs && w_last) begin
          w_next = FIRE;
        end
      end
      FIRE: begin
        start_o = 1'b1;
        w_next  = WAIT;
      end
      WAIT: begin
        if (done_i) begin
          w_next = FILL;
        end
      end
      default: begin
        busy_o = 1'b0;
        w_next = FILL;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_live  <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_hs) begin
        for (int unsigned i = 0; i < INPUT_HEIGHT; i++) begin
          if (r_idx == IDX_W'(i)) begin
            r_data[i] <= data_i;
          end
        end
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
      if (r_state == FIRE) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign data_o      = r_data;
  assign vec_count_o = r_count;

endmodule

// File: doc/fc_layer_feeder.md
FC_LAYER_FEEDER -- requirements
Module: fc_layer_feeder

Interface
REQ-001 Parameter INPUT_HEIGHT, default 4, number of words per vector presented to the downstream node (>=1).
REQ-002 Parameter WORD_SIZE, default 16, bits per word.
REQ-003 Parameter COUNT_WIDTH, default 8, width of the issued-vector counter.
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_i  input  1  asynchronous, active-low reset.
REQ-006 valid_i  input  1  upstream word valid.
REQ-007 data_i  input  WORD_SIZE  upstream word.
REQ-008 ready_o  output  1  feeder can accept a word this cycle.
REQ-009 data_o  output  [INPUT_HEIGHT][WORD_SIZE]  packed vector to node data input.
REQ-010 start_o  output  1  single-cycle start pulse to node.
REQ-011 done_i  input  1  node completion, level or pulse.
REQ-012 busy_o  output  1  high while a vector is issued and not yet completed.
REQ-013 vec_count_o  output  COUNT_WIDTH  number of vectors issued, modulo 2^COUNT_WIDTH.

Function
REQ-014 The FSM SHALL have exactly three states: FILL, FIRE and WAIT.
REQ-015 FILL: ready_o=1; on valid_i&&ready_o, data_i is written to data_o[idx] and idx increments. The first accepted word goes to element 0.
REQ-016 Transition FILL->FIRE on the handshake where idx==INPUT_HEIGHT-1; idx returns to 0 on that same edge.
REQ-017 FIRE lasts exactly one cycle: start_o=1, ready_o=0, vec_count_o increments (wrapping), then the FSM goes to WAIT.
REQ-018 WAIT: ready_o=0, start_o=0, busy_o=1; on done_i=1 the FSM goes to FILL on the next edge.
REQ-019 done_i SHALL be ignored in FILL and FIRE; a done_i coincident with FIRE is not remembered.
REQ-020 data_o SHALL hold constant from the FIRE cycle until the first handshake of the next FILL; only the addressed element changes per handshake.
REQ-021 busy_o SHALL be 1 in FIRE and WAIT, 0 in FILL.
REQ-022 valid_i while ready_o=0 SHALL have no effect; data_i SHALL not be captured.
REQ-023 Minimum cycles per vector SHALL be INPUT_HEIGHT (FILL) + 1 (FIRE) + 1 (WAIT with done_i already high).
REQ-024 INPUT_HEIGHT=1: every accepted word SHALL move the FSM directly to FIRE.
REQ-025 idx width SHALL be $clog2(INPUT_HEIGHT+1); idx never exceeds INPUT_HEIGHT-1.

Reset
REQ-026 While reset_i=0, state=FILL, idx=0, data_o=all zero, start_o=0, busy_o=0 and vec_count_o=0, asynchronously.
REQ-027 Reset asserted mid-FILL or mid-WAIT SHALL discard partial vectors and any pending wait; no start_o is generated on reset release.
REQ-028 ready_o SHALL be 0 while reset_i=0 and 1 from the first edge after reset release.

Structure
REQ-029 The state enum (FILL, FIRE, WAIT) and the default WORD_SIZE constant SHALL live in shared package fc_pkg.
REQ-030 There SHALL be no sub-module; the FSM, index counter and vector register reside in fc_layer_feeder.

Verification
REQ-031 INPUT_HEIGHT=4, words 1,2,3,4 on consecutive cycles -> data_o={4,3,2,1} (element0=1), start_o high exactly one cycle after 4th handshake, vec_count_o=1.
REQ-032 In WAIT, valid_i=1 with data_i=16'hBEEF for 10 cycles, done_i=0 -> ready_o=0 throughout, data_o unchanged, no start_o.
REQ-033 done_i asserted in the FIRE cycle only, then low -> FSM stays in WAIT, busy_o=1; later done_i pulse -> ready_o=1 next cycle.
REQ-034 Reset asserted after 2 of 4 words -> data_o=0, idx=0; the next 4 words 5,6,7,8 -> data_o elements 5,6,7,8 and a single start_o.
REQ-035 COUNT_WIDTH=2, issue 5 vectors with immediate done_i -> vec_count_o sequence 1,2,3,0,1.
REQ-036 valid_i gapped (1,0,1,0...) -> words captured only on handshakes; start_o occurs after the 4th accepted word.
